// File: rtl/stack_sequencer.sv
// -----------------------------------------------------------------------------
// stack_sequencer
//
// Turns one decoded stack instruction into the sequence of DATA_W-wide data
// memory accesses it needs, and produces the next stack pointer value plus the
// update enable for the downstream stack pointer register.
//
//   PUSH / POP : 1 word
//   CALL / RET : 2 words (2*DATA_W-bit PC)
//   INT  / RTI : 3 words (PC plus 3 flag bits)
//
// Stack is full-descending: SP addresses the next free slot.
//   push word : mem[SP] <= w,   SP <= SP - 1
//   pop word  : w = mem[SP+1],  SP <= SP + 1
//
// Ports
//   i_clk, i_reset         rising-edge clock, synchronous active-high reset
//   i_valid, i_op          op request (0 NOP, 1 PUSH, 2 POP, 3 CALL, 4 RET,
//                          5 INT, 6 RTI, 7 reserved); only sampled when idle
//   i_push_data, i_flags   PUSH word in the low half / PC for CALL and INT;
//                          flags pushed by INT
//   i_mem_rdata            combinational read data for o_mem_addr
//   o_busy                 pipeline stall while a sequence is in flight
//   o_mem_*                one access per transfer cycle
//   o_stack_operation,
//   o_stack_pointer        SP update enable and new SP value
//   o_done, o_error        one-cycle completion pulse, with error on bound fault
//   o_pop_data, o_pop_flags results of the last completed pop-type op
// -----------------------------------------------------------------------------
module stack_sequencer #(
  parameter int                DATA_W   = 16,
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] SP_RESET = 32'h0000_0FFF
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_valid,
  input  logic [2:0]            i_op,
  input  logic [2*DATA_W-1:0]   i_push_data,
  input  logic [2:0]            i_flags,
  input  logic [DATA_W-1:0]     i_mem_rdata,
  output logic                  o_busy,
  output logic [ADDR_W-1:0]     o_mem_addr,
  output logic                  o_mem_read,
  output logic                  o_mem_write,
  output logic [DATA_W-1:0]     o_mem_wdata,
  output logic                  o_stack_operation,
  output logic [ADDR_W-1:0]     o_stack_pointer,
  output logic                  o_done,
  output logic [2*DATA_W-1:0]   o_pop_data,
  output logic [2:0]            o_pop_flags,
  output logic                  o_error
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_XFER,
    S_DONE
  } state_e;

  typedef enum logic [2:0] {
    OP_NOP  = 3'd0,
    OP_PUSH = 3'd1,
    OP_POP  = 3'd2,
    OP_CALL = 3'd3,
    OP_RET  = 3'd4,
    OP_INT  = 3'd5,
    OP_RTI  = 3'd6,
    OP_RSVD = 3'd7
  } op_e;

  // Number of memory words an op moves; 0 for NOP/reserved.
  function automatic logic [1:0] word_count(input op_e op);
    case (op)
      OP_PUSH, OP_POP: word_count = 2'd1;
      OP_CALL, OP_RET: word_count = 2'd2;
      OP_INT,  OP_RTI: word_count = 2'd3;
      default:         word_count = 2'd0;
    endcase
  endfunction

  function automatic logic is_push(input op_e op);
    is_push = (op == OP_PUSH) || (op == OP_CALL) || (op == OP_INT);
  endfunction

  state_e              state_q,     state_d;
  op_e                 op_q,        op_d;
  logic [2*DATA_W-1:0] data_q,      data_d;
  logic [2:0]          flags_q,     flags_d;
  logic [ADDR_W-1:0]   sp_q,        sp_d;
  logic [1:0]          k_q,         k_d;
  logic                err_q,       err_d;
  logic [DATA_W-1:0]   lo_q,        lo_d;        // PC low half read by RET/RTI
  logic [2:0]          sflags_q,    sflags_d;    // flags read by RTI
  logic [2*DATA_W-1:0] pop_data_q,  pop_data_d;
  logic [2:0]          pop_flags_q, pop_flags_d;

  op_e               req_op;
  logic [1:0]        req_n;
  logic [ADDR_W:0]   req_n_ext;
  logic              bound_err;
  logic [1:0]        last_k;
  logic [DATA_W-1:0] push_word;

  // Request decode and bound check. One extra bit on the sum keeps the
  // underflow compare free of wrap-around.
  always_comb begin
    req_op    = op_e'(i_op);
    req_n     = word_count(req_op);
    req_n_ext = (ADDR_W+1)'(req_n);
    if (is_push(req_op)) begin
      bound_err = {1'b0, sp_q} < req_n_ext;
    end else begin
      bound_err = ({1'b0, sp_q} + req_n_ext) > {1'b0, SP_RESET};
    end
  end

  // Word written in the current transfer cycle: PC high half goes first so
  // that the pop side sees PC low first.
  always_comb begin
    push_word = '0;
    case (op_q)
      OP_PUSH: push_word = data_q[DATA_W-1:0];
      OP_CALL, OP_INT: begin
        case (k_q)
          2'd0:    push_word = data_q[2*DATA_W-1:DATA_W];
          2'd1:    push_word = data_q[DATA_W-1:0];
          default: push_word = {{(DATA_W-3){1'b0}}, flags_q};
        endcase
      end
      default: push_word = '0;
    endcase
  end

  assign last_k = word_count(op_q) - 2'd1;

  always_comb begin
    // NOTE: every signal assigned here gets a default first; a path that
    // leaves one unassigned would infer a latch.
    state_d     = state_q;
    op_d        = op_q;
    data_d      = data_q;
    flags_d     = flags_q;
    sp_d        = sp_q;
    k_d         = k_q;
    err_d       = err_q;
    lo_d        = lo_q;
    sflags_d    = sflags_q;
    pop_data_d  = pop_data_q;
    pop_flags_d = pop_flags_q;

    o_busy            = 1'b0;
    o_mem_addr        = '0;
    o_mem_read        = 1'b0;
    o_mem_write       = 1'b0;
    o_mem_wdata       = '0;
    o_stack_operation = 1'b0;
    o_stack_pointer   = '0;
    o_done            = 1'b0;
    o_error           = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (i_valid && (req_n != 2'd0)) begin
          op_d    = req_op;
          data_d  = i_push_data;
          flags_d = i_flags;
          k_d     = 2'd0;
          err_d   = bound_err;
          // A bound fault skips the transfer entirely and reports in DONE.
          state_d = bound_err ? S_DONE : S_XFER;
        end
      end

      S_XFER: begin
        o_busy            = 1'b1;
        o_stack_operation = 1'b1;
        if (is_push(op_q)) begin
          o_mem_addr  = sp_q;
          o_mem_write = 1'b1;
          o_mem_wdata = push_word;
          sp_d        = sp_q - 1'b1;
        end else begin
          o_mem_addr = sp_q + 1'b1;
          o_mem_read = 1'b1;
          sp_d       = sp_q + 1'b1;
          // Earlier words park in scratch; the visible pop result only
          // changes on the final word so it holds until the op completes.
          case (op_q)
            OP_POP: pop_data_d = {{DATA_W{1'b0}}, i_mem_rdata};
            OP_RET: begin
              if (k_q == 2'd0) lo_d       = i_mem_rdata;
              else             pop_data_d = {i_mem_rdata, lo_q};
            end
            OP_RTI: begin
              case (k_q)
                2'd0:    sflags_d = i_mem_rdata[2:0];
                2'd1:    lo_d     = i_mem_rdata;
                default: begin
                  pop_data_d  = {i_mem_rdata, lo_q};
                  pop_flags_d = sflags_q;
                end
              endcase
            end
            default: ;
          endcase
        end
        o_stack_pointer = sp_d;
        if (k_q == last_k) state_d = S_DONE;
        else               k_d     = k_q + 2'd1;
      end

      S_DONE: begin
        o_busy  = 1'b1;
        o_done  = 1'b1;
        o_error = err_q;
        err_d   = 1'b0;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign o_pop_data  = pop_data_q;
  assign o_pop_flags = pop_flags_q;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its neighbours.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q     <= S_IDLE;
      op_q        <= OP_NOP;
      data_q      <= '0;
      flags_q     <= '0;
      sp_q        <= SP_RESET;
      k_q         <= '0;
      err_q       <= 1'b0;
      lo_q        <= '0;
      sflags_q    <= '0;
      pop_data_q  <= '0;
      pop_flags_q <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      data_q      <= data_d;
      flags_q     <= flags_d;
      sp_q        <= sp_d;
      k_q         <= k_d;
      err_q       <= err_d;
      lo_q        <= lo_d;
      sflags_q    <= sflags_d;
      pop_data_q  <= pop_data_d;
      pop_flags_q <= pop_flags_d;
    end
  end

endmodule
